exe_ctrl_unit: RTL and testbench

Execute-stage control unit, the parametrised successor to the single-cycle ALU control decoder. It decodes ALUOp/funct into a widened ALU control code and adds the RV32M multiply/divide/remainder subset. Multiply and divide run on an iterative multi-cycle sequencer that stalls the pipeline through a busy/done handshake. It sits between ID/EX and the ALU/EX-MEM register; single-cycle ops pass through combinationally.

---
 rtl/exe_ctrl_pkg.sv | 45 ++++
 rtl/md_iter_core.sv | 124 ++++++++++++
 rtl/exe_ctrl_unit.sv | 167 ++++++++++++++++
 tb/tb_exe_ctrl_unit.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/exe_ctrl_pkg.sv
// Shared constants for the execute-stage control unit: ALU codes, ALUOp classes,
// sequencer states and mul/div op predicates.
package exe_ctrl_pkg;

  localparam logic [3:0] ALU_NOP  = 4'd0;
  localparam logic [3:0] ALU_AND  = 4'd1;
  localparam logic [3:0] ALU_XOR  = 4'd2;
  localparam logic [3:0] ALU_SLL  = 4'd3;
  localparam logic [3:0] ALU_ADD  = 4'd4;
  localparam logic [3:0] ALU_SUB  = 4'd5;
  localparam logic [3:0] ALU_MUL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_DIV  = 4'd8;
  localparam logic [3:0] ALU_DIVU = 4'd9;
  localparam logic [3:0] ALU_REM  = 4'd10;
  localparam logic [3:0] ALU_REMU = 4'd11;
  localparam logic [3:0] ALU_OR   = 4'd12;
  localparam logic [3:0] ALU_SRL  = 4'd13;

  localparam logic [1:0] ALUOP_ITYPE  = 2'b00;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b01;
  localparam logic [1:0] ALUOP_BRANCH = 2'b10;
  localparam logic [1:0] ALUOP_RSVD   = 2'b11;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic is_md_op(input logic [3:0] code);
    return (code == ALU_MUL) || ((code >= ALU_DIV) && (code <= ALU_REMU));
  endfunction

  function automatic logic is_rem_op(input logic [3:0] code);
    return (code == ALU_REM) || (code == ALU_REMU);
  endfunction

  function automatic logic is_signed_div(input logic [3:0] code);
    return (code == ALU_DIV) || (code == ALU_REM);
  endfunction

endpackage

// File: rtl/md_iter_core.sv
// Iterative mul/div datapath: shift-add multiply and restoring divide on magnitudes,
// one step per cycle, with sign and divide-by-zero fix-up on the final result.
module md_iter_core
  import exe_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic            step_i,
  input  logic [3:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic [XLEN-1:0] res_o
);

  logic [3:0]      op_q, op_d;
  logic [XLEN-1:0] orig_q, orig_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] sh_q, sh_d;
  logic [XLEN-1:0] dv_q, dv_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic            dz_q, dz_d;

  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   rem_sh, divisor_ext;
  logic            ge;
  logic [XLEN-1:0] acc_n, sh_n, dv_n;
  logic [XLEN-1:0] quo_fix, rem_fix;

  always_comb begin
    a_neg = is_signed_div(op_i) & rs1_i[XLEN-1];
    b_neg = is_signed_div(op_i) & rs2_i[XLEN-1];
    a_mag = a_neg ? (~rs1_i + 1'b1) : rs1_i;
    b_mag = b_neg ? (~rs2_i + 1'b1) : rs2_i;
  end

  // One iteration; acc/sh hold product/multiplier for MUL, remainder/quotient for divides.
  always_comb begin
    rem_sh      = {acc_q, sh_q[XLEN-1]};
    divisor_ext = {1'b0, dv_q};
    ge          = (rem_sh >= divisor_ext);
    if (op_q == ALU_MUL) begin
      acc_n = acc_q + (sh_q[0] ? dv_q : '0);
      sh_n  = sh_q >> 1;
      dv_n  = dv_q << 1;
    end else begin
      acc_n = ge ? XLEN'(rem_sh - divisor_ext) : rem_sh[XLEN-1:0];
      sh_n  = {sh_q[XLEN-2:0], ge};
      dv_n  = dv_q;
    end
  end

  // Meaningful only in the cycle of the final step, when the top captures it.
  always_comb begin
    quo_fix = neg_quo_q ? (~sh_n + 1'b1) : sh_n;
    rem_fix = neg_rem_q ? (~acc_n + 1'b1) : acc_n;
    if (op_q == ALU_MUL) begin
      res_o = acc_n;
    end else if (is_rem_op(op_q)) begin
      res_o = dz_q ? orig_q : rem_fix;
    end else if (is_md_op(op_q)) begin
      res_o = dz_q ? '1 : quo_fix;
    end else begin
      res_o = '0;
    end
  end

  always_comb begin
    op_d      = op_q;
    orig_d    = orig_q;
    acc_d     = acc_q;
    sh_d      = sh_q;
    dv_d      = dv_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    if (load_i) begin
      op_d      = op_i;
      orig_d    = rs1_i;
      acc_d     = '0;
      neg_quo_d = a_neg ^ b_neg;
      neg_rem_d = a_neg;
      dz_d      = (rs2_i == '0);
      if (op_i == ALU_MUL) begin
        sh_d = rs2_i;
        dv_d = rs1_i;
      end else begin
        sh_d = a_mag;
        dv_d = b_mag;
      end
    end else if (step_i) begin
      acc_d = acc_n;
      sh_d  = sh_n;
      dv_d  = dv_n;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_q      <= ALU_NOP;
      orig_q    <= '0;
      acc_q     <= '0;
      sh_q      <= '0;
      dv_q      <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      op_q      <= op_d;
      orig_q    <= orig_d;
      acc_q     <= acc_d;
      sh_q      <= sh_d;
      dv_q      <= dv_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
    end
  end

endmodule

// File: rtl/exe_ctrl_unit.sv
// Execute-stage control: ALUOp/funct decoder plus IDLE/RUN/DONE sequencer for RV32M.
// Define EXE_MD_EARLY_EN to let zero-operand mul/div ops skip the iterative RUN phase.
module exe_ctrl_unit
  import exe_ctrl_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned CTRL_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              flush_i,
  input  logic [1:0]        ALUOp_i,
  input  logic [9:0]        funct_i,
  input  logic [XLEN-1:0]   rs1_i,
  input  logic [XLEN-1:0]   rs2_i,
  output logic [CTRL_W-1:0] ALUCtrl_o,
  output logic              md_busy_o,
  output logic              md_done_o,
  output logic [XLEN-1:0]   md_result_o
);

  localparam int unsigned CntW = $clog2(XLEN);
  localparam logic [CntW-1:0] CntLast = CntW'(XLEN - 1);

  logic [6:0]      funct7;
  logic [2:0]      funct3;
  logic [3:0]      alu_code;
  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            md_start;
  logic            core_load, core_step;
  logic [XLEN-1:0] core_res;

  assign funct7 = funct_i[9:3];
  assign funct3 = funct_i[2:0];

  always_comb begin
    alu_code = ALU_NOP;
    case (ALUOp_i)
      ALUOP_ITYPE: begin
        case (funct3)
          3'b000:  alu_code = ALU_ADD;
          3'b101:  alu_code = ALU_SRA;
          3'b110:  alu_code = ALU_OR;
          default: alu_code = ALU_NOP;
        endcase
      end
      ALUOP_RTYPE: begin
        if (funct7 == F7_BASE) begin
          case (funct3)
            3'b111:  alu_code = ALU_AND;
            3'b100:  alu_code = ALU_XOR;
            3'b001:  alu_code = ALU_SLL;
            3'b000:  alu_code = ALU_ADD;
            3'b110:  alu_code = ALU_OR;
            3'b101:  alu_code = ALU_SRL;
            default: alu_code = ALU_NOP;
          endcase
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          alu_code = ALU_SUB;
        end else if (funct7 == F7_MULDIV) begin
          case (funct3)
            3'b000:  alu_code = ALU_MUL;
            3'b100:  alu_code = ALU_DIV;
            3'b101:  alu_code = ALU_DIVU;
            3'b110:  alu_code = ALU_REM;
            3'b111:  alu_code = ALU_REMU;
            default: alu_code = ALU_NOP;
          endcase
        end
      end
      ALUOP_BRANCH: alu_code = ALU_SUB;
      default:      alu_code = ALU_NOP;
    endcase
  end

  assign ALUCtrl_o = CTRL_W'(alu_code);

  assign md_start  = (state_q == ST_IDLE) & start_i & is_md_op(alu_code) & ~flush_i;
  assign md_busy_o = md_start | (state_q == ST_RUN);
  assign md_done_o = (state_q == ST_DONE);
  assign md_result_o = result_q;

`ifdef EXE_MD_EARLY_EN
  logic            early_hit;
  logic [XLEN-1:0] early_res;

  // Zero operands have trivially known results, so these bypass the iterative core.
  always_comb begin
    early_hit = 1'b0;
    early_res = '0;
    if (alu_code == ALU_MUL) begin
      early_hit = (rs1_i == '0) || (rs2_i == '0);
    end else begin
      early_hit = (rs2_i == '0);
      early_res = is_rem_op(alu_code) ? rs1_i : '1;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    core_load = 1'b0;
    core_step = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (md_start) begin
          core_load = 1'b1;
          cnt_d     = '0;
          state_d   = ST_RUN;
`ifdef EXE_MD_EARLY_EN
          if (early_hit) begin
            state_d  = ST_DONE;
            result_d = early_res;
          end
`endif
        end
      end
      ST_RUN: begin
        // Flush wins over completion so an aborted op never reports a result.
        if (flush_i) begin
          state_d = ST_IDLE;
        end else begin
          core_step = 1'b1;
          if (cnt_q == CntLast) begin
            state_d  = ST_DONE;
            result_d = core_res;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  md_iter_core #(
    .XLEN(XLEN)
  ) u_md_iter_core (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (core_load),
    .step_i (core_step),
    .op_i   (alu_code),
    .rs1_i  (rs1_i),
    .rs2_i  (rs2_i),
    .res_o  (core_res)
  );

endmodule

// File: tb/tb_exe_ctrl_unit.sv
// Scoreboard bench for exe_ctrl_unit: stimulus pushes expectations, a negedge monitor checks.
module tb_exe_ctrl_unit;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CTRL_W = 4;
`ifdef EXE_MD_EARLY_EN
  localparam bit EarlyEn = 1'b1;
`else
  localparam bit EarlyEn = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_i;
  logic              start_i;
  logic              flush_i;
  logic [1:0]        ALUOp_i;
  logic [9:0]        funct_i;
  logic [XLEN-1:0]   rs1_i;
  logic [XLEN-1:0]   rs2_i;
  logic [CTRL_W-1:0] ALUCtrl_o;
  logic              md_busy_o;
  logic              md_done_o;
  logic [XLEN-1:0]   md_result_o;

  exe_ctrl_unit #(
    .XLEN   (XLEN),
    .CTRL_W (CTRL_W)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .flush_i     (flush_i),
    .ALUOp_i     (ALUOp_i),
    .funct_i     (funct_i),
    .rs1_i       (rs1_i),
    .rs2_i       (rs2_i),
    .ALUCtrl_o   (ALUCtrl_o),
    .md_busy_o   (md_busy_o),
    .md_done_o   (md_done_o),
    .md_result_o (md_result_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] val;
    int          due;
  } md_exp_t;

  typedef struct {
    string       name;
    logic [31:0] val;
  } dec_exp_t;

  md_exp_t     md_q[$];
  dec_exp_t    dec_q[$];
  int          cyc = 0;
  int          checks = 0;
  int          passes = 0;
  logic [31:0] last_res = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  // Monitor: pops expectations whenever the DUT presents a result.
  always @(negedge clk) begin
    dec_exp_t d;
    md_exp_t  e;
    if (dec_q.size() > 0) begin
      d = dec_q.pop_front();
      check(d.name, 32'(ALUCtrl_o), d.val);
    end
    if (md_done_o) begin
      if (md_q.size() == 0) begin
        check("unexpected_done", 32'(md_done_o), 32'd0);
      end else begin
        e = md_q.pop_front();
        check(e.name, md_result_o, e.val);
        check({e.name, "_cycle"}, 32'(cyc), 32'(e.due));
        check({e.name, "_busy_in_done"}, 32'(md_busy_o), 32'd0);
      end
    end
  end

  task automatic dec(input string name, input logic [1:0] op, input logic [9:0] f,
                     input logic [3:0] exp);
    dec_exp_t d;
    @(posedge clk);
    #1;
    ALUOp_i = op;
    funct_i = f;
    d.name  = name;
    d.val   = 32'(exp);
    dec_q.push_back(d);
  endtask

  // Called just after a rising edge; returns just after the following rising edge.
  task automatic md_go(input string name, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input bit early,
                       input bit push);
    md_exp_t e;
    bit      eff_early;
    eff_early = EarlyEn && early;
    ALUOp_i = 2'b01;
    funct_i = {7'b0000001, f3};
    rs1_i   = a;
    rs2_i   = b;
    start_i = 1'b1;
    #1;
    check({name, "_busy_start"}, 32'(md_busy_o), 32'd1);
    if (push) begin
      e.name = name;
      e.val  = exp;
      e.due  = cyc + 1 + (eff_early ? 0 : int'(XLEN));
      md_q.push_back(e);
      last_res = exp;
    end
    @(posedge clk);
    #1;
    start_i = 1'b0;
    ALUOp_i = 2'b11;
    check({name, "_busy_next"}, 32'(md_busy_o), eff_early ? 32'd0 : 32'd1);
  endtask

  task automatic md_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    rst_i   = 1'b1;
    start_i = 1'b0;
    flush_i = 1'b0;
    ALUOp_i = 2'b11;
    funct_i = '0;
    rs1_i   = '0;
    rs2_i   = '0;
    #1;
    check("reset_busy", 32'(md_busy_o), 32'd0);
    check("reset_done", 32'(md_done_o), 32'd0);
    check("reset_result", md_result_o, 32'd0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;

    dec("i_add",   2'b00, {7'b0000000, 3'b000}, 4'd4);
    dec("i_sra",   2'b00, {7'b0100000, 3'b101}, 4'd7);
    dec("i_or",    2'b00, {7'b0000000, 3'b110}, 4'd12);
    dec("i_001",   2'b00, {7'b0000000, 3'b001}, 4'd0);
    dec("i_111",   2'b00, {7'b0000000, 3'b111}, 4'd0);
    dec("r_and",   2'b01, {7'b0000000, 3'b111}, 4'd1);
    dec("r_xor",   2'b01, {7'b0000000, 3'b100}, 4'd2);
    dec("r_sll",   2'b01, {7'b0000000, 3'b001}, 4'd3);
    dec("r_add",   2'b01, {7'b0000000, 3'b000}, 4'd4);
    dec("r_or",    2'b01, {7'b0000000, 3'b110}, 4'd12);
    dec("r_srl",   2'b01, {7'b0000000, 3'b101}, 4'd13);
    dec("r_011",   2'b01, {7'b0000000, 3'b011}, 4'd0);
    dec("r_sub",   2'b01, {7'b0100000, 3'b000}, 4'd5);
    dec("r_alt101", 2'b01, {7'b0100000, 3'b101}, 4'd0);
    dec("r_mul",   2'b01, {7'b0000001, 3'b000}, 4'd6);
    dec("r_div",   2'b01, {7'b0000001, 3'b100}, 4'd8);
    dec("r_divu",  2'b01, {7'b0000001, 3'b101}, 4'd9);
    dec("r_rem",   2'b01, {7'b0000001, 3'b110}, 4'd10);
    dec("r_remu",  2'b01, {7'b0000001, 3'b111}, 4'd11);
    dec("r_md001", 2'b01, {7'b0000001, 3'b001}, 4'd0);
    dec("r_f7bad", 2'b01, {7'b1111111, 3'b000}, 4'd0);
    dec("branch",  2'b10, {7'b0000000, 3'b111}, 4'd5);
    dec("rsvd",    2'b11, {7'b0000001, 3'b000}, 4'd0);
    @(posedge clk);
    #1;

    md_go("mul_7_m3", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 1'b1);
    md_wait(XLEN + 1);
    md_go("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 1'b1);
    md_wait(XLEN + 1);
    md_go("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 1'b1);
    md_wait(XLEN + 1);
    md_go("divu_ovf", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1);
    md_wait(XLEN + 1);
    md_go("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b1);
    md_wait(XLEN + 1);
    md_go("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1);
    md_wait(XLEN + 1);
    md_go("div_by0", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 1'b1);
    md_wait(XLEN + 1);
    md_go("rem_by0", 3'b110, 32'd5, 32'd0, 32'd5, 1'b1, 1'b1);
    md_wait(XLEN + 1);
    md_go("remu_m5_by0", 3'b111, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1'b1, 1'b1);
    md_wait(XLEN + 1);
    md_go("divu_100_7", 3'b101, 32'd100, 32'd7, 32'd14, 1'b0, 1'b1);
    md_wait(XLEN + 1);
    md_go("remu_100_7", 3'b111, 32'd100, 32'd7, 32'd2, 1'b0, 1'b1);
    md_wait(XLEN + 1);
    md_go("div_7_m2", 3'b100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 1'b1);
    md_wait(XLEN + 1);
    md_go("rem_7_m2", 3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0, 1'b1);
    md_wait(XLEN + 1);
    md_go("mul_zero", 3'b000, 32'd0, 32'd9, 32'd0, 1'b1, 1'b1);
    md_wait(XLEN + 1);
    md_go("mul_wrap", 3'b000, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b0, 1'b1);
    md_wait(XLEN + 1);
    md_go("mul_m1_m1", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1);
    md_wait(XLEN + 1);

    // Flush in RUN cycle 10: no done pulse, result held, immediate restart.
    md_go("flushed_div", 3'b100, 32'd100, 32'd7, 32'd0, 1'b0, 1'b0);
    md_wait(9);
    flush_i = 1'b1;
    #1;
    check("flush_busy_in_run", 32'(md_busy_o), 32'd1);
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    check("flush_idle_busy", 32'(md_busy_o), 32'd0);
    check("flush_result_held", md_result_o, last_res);
    md_go("after_flush", 3'b101, 32'd100, 32'd7, 32'd14, 1'b0, 1'b1);
    md_wait(XLEN + 1);

    // Asynchronous reset mid-RUN discards the op and clears outputs at once.
    md_go("reset_abort", 3'b000, 32'd3, 32'd5, 32'd15, 1'b0, 1'b0);
    md_wait(5);
    rst_i = 1'b1;
    #1;
    check("midrst_busy", 32'(md_busy_o), 32'd0);
    check("midrst_done", 32'(md_done_o), 32'd0);
    check("midrst_result", md_result_o, 32'd0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(posedge clk);
    #1;
    md_go("mul_after_rst", 3'b000, 32'd3, 32'd5, 32'd15, 1'b0, 1'b1);
    md_wait(XLEN + 1);

    for (int i = 0; i < 100 && (md_q.size() > 0 || dec_q.size() > 0); i++) @(posedge clk);
    @(negedge clk);
    check("md_queue_drained", 32'(md_q.size()), 32'd0);
    check("dec_queue_drained", 32'(dec_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
